// File: rtl/albers_layer_renderer.sv
// Nested-rectangle (Albers) colour renderer: sequential shadow loader, frame-synchronous commit,
// two-stage hit/priority pipeline. Define ALBERS_EASE_EN to ease extents toward their targets per frame.
module albers_layer_renderer #(
    parameter int unsigned NUM_LAYERS = 7,
    parameter int          H_CENTER   = 640,
    parameter int          V_CENTER   = 480,
    parameter int unsigned MASK_BASE  = 5,
    parameter int unsigned EASE_STEP  = 4
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        display_en,
    input  logic [11:0] h_count,
    input  logic [11:0] v_count,
    input  logic        frame_tick,
    input  logic        new_target,
    input  logic [31:0] rnd_in,
    output logic        busy,
    output logic [3:0]  r_out,
    output logic [3:0]  g_out,
    output logic [3:0]  b_out
);

    localparam int unsigned KW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD_A  = 2'd1;
    localparam logic [1:0] S_LOAD_B  = 2'd2;
    localparam logic [1:0] S_LOAD_BG = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic          busy_q, busy_d;
    logic          sv_q, sv_d;
    logic          commit;

    logic [10:0] sh_left_q  [NUM_LAYERS];
    logic [10:0] sh_right_q [NUM_LAYERS];
    logic [10:0] sh_top_q   [NUM_LAYERS];
    logic [10:0] sh_bot_q   [NUM_LAYERS];
    logic [3:0]  sh_r_q     [NUM_LAYERS];
    logic [3:0]  sh_g_q     [NUM_LAYERS];
    logic [3:0]  sh_b_q     [NUM_LAYERS];
    logic [3:0]  sh_bg_r_q, sh_bg_g_q, sh_bg_b_q;

    logic [10:0] act_left_q  [NUM_LAYERS];
    logic [10:0] act_right_q [NUM_LAYERS];
    logic [10:0] act_top_q   [NUM_LAYERS];
    logic [10:0] act_bot_q   [NUM_LAYERS];
    logic [3:0]  act_r_q     [NUM_LAYERS];
    logic [3:0]  act_g_q     [NUM_LAYERS];
    logic [3:0]  act_b_q     [NUM_LAYERS];
    logic [3:0]  bg_r_q, bg_g_q, bg_b_q;

    logic [NUM_LAYERS-1:0] hit_d, hit_q;
    logic                  de_q;
    logic [3:0]            r_d, g_d, b_d, r_q, g_q, b_q;
    logic                  found;
    logic                  unused_rnd;

    assign unused_rnd = ^rnd_in[31:30];

    function automatic logic [10:0] layer_mask(input logic [KW-1:0] idx);
        int unsigned w;
        w = MASK_BASE + 32'(idx);
        if (w >= 11) return 11'h7FF;
        return 11'h7FF >> (11 - w);
    endfunction

    // Signed 13-bit bounds: a lower bound below zero simply never clips.
    function automatic logic axis_hit(input int center, input logic [10:0] lo_ext,
                                      input logic [10:0] hi_ext, input logic [11:0] pos);
        logic signed [12:0] c, lb, ub, p;
        c  = 13'(center);
        lb = c - $signed({2'b00, lo_ext});
        ub = c + $signed({2'b00, hi_ext});
        p  = $signed({1'b0, pos});
        return (lb < p) && (p < ub);
    endfunction

    // shadow_valid is sampled before a same-cycle new_target clears it.
    assign commit = frame_tick && sv_q && !busy_q;
    assign busy   = busy_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        busy_d  = busy_q;
        sv_d    = commit ? 1'b0 : sv_q;
        case (state_q)
            S_IDLE: begin
                if (new_target) begin
                    state_d = S_LOAD_A;
                    k_d     = '0;
                    busy_d  = 1'b1;
                    sv_d    = 1'b0;
                end
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: begin
                if (k_q == KW'(NUM_LAYERS - 1)) begin
                    state_d = S_LOAD_BG;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_BG: begin
                sv_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            busy_q  <= 1'b0;
            sv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            sv_q    <= sv_d;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                sh_left_q[i]  <= '0;
                sh_right_q[i] <= '0;
                sh_top_q[i]   <= '0;
                sh_bot_q[i]   <= '0;
                sh_r_q[i]     <= '0;
                sh_g_q[i]     <= '0;
                sh_b_q[i]     <= '0;
            end
            sh_bg_r_q <= '0;
            sh_bg_g_q <= '0;
            sh_bg_b_q <= '0;
        end else begin
            case (state_q)
                S_LOAD_A: begin
                    sh_left_q[k_q]  <= rnd_in[10:0] & layer_mask(k_q);
                    sh_right_q[k_q] <= rnd_in[21:11] & layer_mask(k_q);
                    sh_r_q[k_q]     <= rnd_in[25:22];
                    sh_g_q[k_q]     <= rnd_in[29:26];
                end
                S_LOAD_B: begin
                    sh_top_q[k_q] <= rnd_in[10:0] & layer_mask(k_q);
                    sh_bot_q[k_q] <= rnd_in[21:11] & layer_mask(k_q);
                    sh_b_q[k_q]   <= rnd_in[25:22];
                end
                S_LOAD_BG: begin
                    sh_bg_r_q <= rnd_in[3:0];
                    sh_bg_g_q <= rnd_in[7:4];
                    sh_bg_b_q <= rnd_in[11:8];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                act_r_q[i] <= '0;
                act_g_q[i] <= '0;
                act_b_q[i] <= '0;
            end
            bg_r_q <= '0;
            bg_g_q <= '0;
            bg_b_q <= '0;
        end else if (commit) begin
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                act_r_q[i] <= sh_r_q[i];
                act_g_q[i] <= sh_g_q[i];
                act_b_q[i] <= sh_b_q[i];
            end
            bg_r_q <= sh_bg_r_q;
            bg_g_q <= sh_bg_g_q;
            bg_b_q <= sh_bg_b_q;
        end
    end

`ifdef ALBERS_EASE_EN
    logic [10:0] tgt_left_q  [NUM_LAYERS];
    logic [10:0] tgt_right_q [NUM_LAYERS];
    logic [10:0] tgt_top_q   [NUM_LAYERS];
    logic [10:0] tgt_bot_q   [NUM_LAYERS];

    function automatic logic [10:0] ease(input logic [10:0] cur, input logic [10:0] tgt);
        logic [10:0] step;
        step = 11'(EASE_STEP);
        if (cur < tgt) return (tgt - cur <= step) ? tgt : cur + step;
        return (cur - tgt <= step) ? tgt : cur - step;
    endfunction

    // On a committing tick the extents already step toward the freshly committed target.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                tgt_left_q[i]  <= '0;
                tgt_right_q[i] <= '0;
                tgt_top_q[i]   <= '0;
                tgt_bot_q[i]   <= '0;
                act_left_q[i]  <= '0;
                act_right_q[i] <= '0;
                act_top_q[i]   <= '0;
                act_bot_q[i]   <= '0;
            end
        end else if (frame_tick) begin
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                if (commit) begin
                    tgt_left_q[i]  <= sh_left_q[i];
                    tgt_right_q[i] <= sh_right_q[i];
                    tgt_top_q[i]   <= sh_top_q[i];
                    tgt_bot_q[i]   <= sh_bot_q[i];
                end
                act_left_q[i]  <= ease(act_left_q[i],  commit ? sh_left_q[i]  : tgt_left_q[i]);
                act_right_q[i] <= ease(act_right_q[i], commit ? sh_right_q[i] : tgt_right_q[i]);
                act_top_q[i]   <= ease(act_top_q[i],   commit ? sh_top_q[i]   : tgt_top_q[i]);
                act_bot_q[i]   <= ease(act_bot_q[i],   commit ? sh_bot_q[i]   : tgt_bot_q[i]);
            end
        end
    end
`else
    localparam int unsigned unused_ease_step = EASE_STEP;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                act_left_q[i]  <= '0;
                act_right_q[i] <= '0;
                act_top_q[i]   <= '0;
                act_bot_q[i]   <= '0;
            end
        end else if (commit) begin
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                act_left_q[i]  <= sh_left_q[i];
                act_right_q[i] <= sh_right_q[i];
                act_top_q[i]   <= sh_top_q[i];
                act_bot_q[i]   <= sh_bot_q[i];
            end
        end
    end
`endif

    always_comb begin
        hit_d = '0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            hit_d[i] = axis_hit(H_CENTER, act_left_q[i], act_right_q[i], h_count) &&
                       axis_hit(V_CENTER, act_top_q[i], act_bot_q[i], v_count);
        end
    end

    always_comb begin
        r_d   = bg_r_q;
        g_d   = bg_g_q;
        b_d   = bg_b_q;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (hit_q[i] && !found) begin
                found = 1'b1;
                r_d   = act_r_q[i];
                g_d   = act_g_q[i];
                b_d   = act_b_q[i];
            end
        end
        if (!de_q) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            hit_q <= '0;
            de_q  <= 1'b0;
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
        end else begin
            hit_q <= hit_d;
            de_q  <= display_en;
            r_q   <= r_d;
            g_q   <= g_d;
            b_q   <= b_d;
        end
    end

    assign r_out = r_q;
    assign g_out = g_q;
    assign b_out = b_q;

endmodule

// File: tb/tb_albers_layer_renderer.sv
// Directed table-driven bench for albers_layer_renderer (NUM_LAYERS=2, default build).
module tb_albers_layer_renderer;

    typedef struct {
        logic [11:0] h;
        logic [11:0] v;
        logic        de;
        logic [11:0] rgb;
        string       name;
    } vec_t;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        display_en;
    logic [11:0] h_count;
    logic [11:0] v_count;
    logic        frame_tick;
    logic        new_target;
    logic [31:0] rnd_in;
    logic        busy;
    logic [3:0]  r_out, g_out, b_out;
    logic [11:0] rgb;

    int vec_cnt = 0;
    int err_cnt = 0;

    vec_t        tab0 [3];
    vec_t        tab1 [12];
    vec_t        tab2 [13];
    logic [31:0] w1 [5];
    logic [31:0] w2 [5];
    logic [31:0] w3 [5];

    always #5 clk_in = ~clk_in;

    assign rgb = {r_out, g_out, b_out};

    albers_layer_renderer #(
        .NUM_LAYERS(2),
        .H_CENTER  (640),
        .V_CENTER  (480),
        .MASK_BASE (5),
        .EASE_STEP (4)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .display_en(display_en),
        .h_count   (h_count),
        .v_count   (v_count),
        .frame_tick(frame_tick),
        .new_target(new_target),
        .rnd_in    (rnd_in),
        .busy      (busy),
        .r_out     (r_out),
        .g_out     (g_out),
        .b_out     (b_out)
    );

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        h_count    = v.h;
        v_count    = v.v;
        display_en = v.de;
        step();
        step();
        check(v.name, rgb, v.rgb);
    endtask

    task automatic run_load(input logic [31:0] w [5], input int tick_at, input bit tick_first);
        new_target = 1'b1;
        frame_tick = tick_first;
        rnd_in     = w[0];
        step();
        new_target = 1'b0;
        frame_tick = 1'b0;
        check("busy_rise", {11'b0, busy}, 12'd1);
        for (int i = 0; i < 5; i++) begin
            rnd_in     = w[i];
            frame_tick = (i == tick_at);
            step();
            frame_tick = 1'b0;
            if (i == 3) check("busy_hold", {11'b0, busy}, 12'd1);
        end
        check("busy_fall", {11'b0, busy}, 12'd0);
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; display_en = 1'b0; h_count = '0; v_count = '0;
        frame_tick = 1'b0; new_target = 1'b0; rnd_in = '0;

        tab0[0] = '{12'd640, 12'd480, 1'b1, 12'h000, "post_rst_centre"};
        tab0[1] = '{12'd0,   12'd0,   1'b1, 12'h000, "post_rst_origin"};
        tab0[2] = '{12'd630, 12'd470, 1'b1, 12'h000, "post_rst_inner"};

        // 0x0ABCDE14: extents 20/27 on both axes for both layers, colour A/2/A, background 4/1/E
        tab1[0]  = '{12'd640,  12'd480,  1'b1, 12'hA2A, "c1_centre"};
        tab1[1]  = '{12'd0,    12'd0,    1'b1, 12'h41E, "c1_origin_bg"};
        tab1[2]  = '{12'd620,  12'd480,  1'b1, 12'h41E, "c1_left_edge_out"};
        tab1[3]  = '{12'd621,  12'd480,  1'b1, 12'hA2A, "c1_left_edge_in"};
        tab1[4]  = '{12'd666,  12'd480,  1'b1, 12'hA2A, "c1_right_edge_in"};
        tab1[5]  = '{12'd667,  12'd480,  1'b1, 12'h41E, "c1_right_edge_out"};
        tab1[6]  = '{12'd640,  12'd460,  1'b1, 12'h41E, "c1_top_edge_out"};
        tab1[7]  = '{12'd640,  12'd461,  1'b1, 12'hA2A, "c1_top_edge_in"};
        tab1[8]  = '{12'd640,  12'd506,  1'b1, 12'hA2A, "c1_bot_edge_in"};
        tab1[9]  = '{12'd640,  12'd507,  1'b1, 12'h41E, "c1_bot_edge_out"};
        tab1[10] = '{12'd4095, 12'd4095, 1'b1, 12'h41E, "c1_far_corner"};
        tab1[11] = '{12'd640,  12'd480,  1'b0, 12'h000, "c1_blank"};

        // Layer0: L2 R3 T2 B3 rgb 1/2/3; layer1: L40 R50 T30 B60 rgb 5/6/7; bg 8/9/A
        tab2[0]  = '{12'd640, 12'd480, 1'b1, 12'h123, "c2_l0_centre"};
        tab2[1]  = '{12'd642, 12'd482, 1'b1, 12'h123, "c2_l0_corner"};
        tab2[2]  = '{12'd643, 12'd480, 1'b1, 12'h567, "c2_l0_right_out"};
        tab2[3]  = '{12'd638, 12'd480, 1'b1, 12'h567, "c2_l0_left_out"};
        tab2[4]  = '{12'd639, 12'd478, 1'b1, 12'h567, "c2_l0_top_out"};
        tab2[5]  = '{12'd601, 12'd451, 1'b1, 12'h567, "c2_l1_corner"};
        tab2[6]  = '{12'd600, 12'd480, 1'b1, 12'h89A, "c2_l1_left_out"};
        tab2[7]  = '{12'd689, 12'd539, 1'b1, 12'h567, "c2_l1_far_corner"};
        tab2[8]  = '{12'd690, 12'd480, 1'b1, 12'h89A, "c2_l1_right_out"};
        tab2[9]  = '{12'd640, 12'd540, 1'b1, 12'h89A, "c2_l1_bot_out"};
        tab2[10] = '{12'd640, 12'd450, 1'b1, 12'h89A, "c2_l1_top_out"};
        tab2[11] = '{12'd0,   12'd0,   1'b1, 12'h89A, "c2_origin_bg"};
        tab2[12] = '{12'd640, 12'd480, 1'b0, 12'h000, "c2_blank"};

        for (int i = 0; i < 5; i++) w1[i] = 32'h0ABCDE14;
        w2[0] = 32'd2 | (32'd35 << 11) | (32'd1 << 22) | (32'd2 << 26);
        w2[1] = 32'd2 | (32'd3 << 11) | (32'd3 << 22);
        w2[2] = 32'h428 | (32'd50 << 11) | (32'd5 << 22) | (32'd6 << 26);
        w2[3] = 32'd30 | (32'd60 << 11) | (32'd7 << 22);
        w2[4] = 32'h00000A98;
        for (int i = 0; i < 5; i++) w3[i] = 32'hFFFFFFFF;

        step();
        step();
        check("rst_busy", {11'b0, busy}, 12'd0);
        check("rst_rgb", rgb, 12'h000);
        reset = 1'b1;
        step();

        // Reset asserted asynchronously in the middle of a load
        new_target = 1'b1;
        rnd_in     = 32'hFFFFFFFF;
        step();
        new_target = 1'b0;
        step();
        step();
        step();
        check("midload_busy", {11'b0, busy}, 12'd1);
        #2 reset = 1'b0;
        #1 check("async_rst_busy", {11'b0, busy}, 12'd0);
        step();
        reset = 1'b1;
        step();
        pulse_tick();
        for (int i = 0; i < 3; i++) apply_vec(tab0[i]);

        run_load(w1, -1, 1'b0);
        apply_vec('{12'd640, 12'd480, 1'b1, 12'h000, "precommit_black"});
        pulse_tick();
        for (int i = 0; i < 12; i++) apply_vec(tab1[i]);

        // Latency across the layer-0 right edge
        h_count = 12'd666; v_count = 12'd480; display_en = 1'b1;
        step();
        step();
        check("lat_inside", rgb, 12'hA2A);
        h_count = 12'd667;
        step();
        check("lat_1cyc_hold", rgb, 12'hA2A);
        step();
        check("lat_2cyc_change", rgb, 12'h41E);

        // Blanking inside layer 0
        h_count = 12'd640;
        step();
        step();
        check("blank_pre", rgb, 12'hA2A);
        display_en = 1'b0;
        step();
        check("blank_1cyc_hold", rgb, 12'hA2A);
        step();
        check("blank_2cyc_black", rgb, 12'h000);
        display_en = 1'b1;

        // frame_tick during load cycle 2 must not commit
        run_load(w2, 1, 1'b0);
        apply_vec('{12'd640, 12'd480, 1'b1, 12'hA2A, "tick_in_load_centre"});
        apply_vec('{12'd0,   12'd0,   1'b1, 12'h41E, "tick_in_load_bg"});

        // Same-cycle frame_tick + new_target: commits composition 2, then loads composition 3
        run_load(w3, -1, 1'b1);
        for (int i = 0; i < 13; i++) apply_vec(tab2[i]);

        pulse_tick();
        apply_vec('{12'd0, 12'd0, 1'b1, 12'hFFF, "c3_origin_bg"});

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
